// File: rtl/iob_asym_fifo_ctrl.sv
// Sequences an external asymmetric 2-port RAM as a FIFO: enables, wrapping addresses, occupancy in min-width units.
// Flags and r_valid are registered; optional IOB_ASYM_FIFO_ERR_EN adds sticky overflow/underflow outputs.
module iob_asym_fifo_ctrl #(
    parameter int W_DATA_W = 32,
    parameter int R_DATA_W = 8,
    parameter int ADDR_W   = 10,
    localparam int MAXDATA_W = (W_DATA_W > R_DATA_W) ? W_DATA_W : R_DATA_W,
    localparam int MINDATA_W = (W_DATA_W > R_DATA_W) ? R_DATA_W : W_DATA_W,
    localparam int N         = MAXDATA_W / MINDATA_W,
    localparam int MINADDR_W = ADDR_W - $clog2(N),
    localparam int W_ADDR_W  = (W_DATA_W == MAXDATA_W) ? MINADDR_W : ADDR_W,
    localparam int R_ADDR_W  = (R_DATA_W == MAXDATA_W) ? MINADDR_W : ADDR_W,
    localparam int W_INC     = W_DATA_W / MINDATA_W,
    localparam int R_DEC     = R_DATA_W / MINDATA_W
) (
    input  logic                ap_clk,
    input  logic                ap_rst_n,
    input  logic                flush,
    input  logic                w_en,
    input  logic [W_DATA_W-1:0] w_data,
    output logic                w_full,
    input  logic                r_en,
    output logic [R_DATA_W-1:0] r_data,
    output logic                r_valid,
    output logic                r_empty,
    output logic [ADDR_W:0]     level,
    output logic                ram_w_en,
    output logic [W_DATA_W-1:0] ram_w_data,
    output logic [W_ADDR_W-1:0] ram_w_addr,
    output logic                ram_r_en,
    output logic [R_ADDR_W-1:0] ram_r_addr,
`ifdef IOB_ASYM_FIFO_ERR_EN
    output logic                overflow,
    output logic                underflow,
`endif
    input  logic [R_DATA_W-1:0] ram_r_data
);

    localparam logic [ADDR_W:0] W_INC_L  = (ADDR_W+1)'(W_INC);
    localparam logic [ADDR_W:0] R_DEC_L  = (ADDR_W+1)'(R_DEC);
    localparam logic [ADDR_W:0] FULL_THR = (ADDR_W+1)'((1 << ADDR_W) - W_INC);

    logic                wr_ok, rd_ok;
    logic [W_ADDR_W-1:0] w_ptr_q, w_ptr_d;
    logic [R_ADDR_W-1:0] r_ptr_q, r_ptr_d;
    logic [ADDR_W:0]     level_q, level_d;
    logic                w_full_q, w_full_d;
    logic                r_empty_q, r_empty_d;
    logic                r_valid_q, r_valid_d;

    always_comb begin
        wr_ok   = w_en & ~w_full_q & ~flush;
        rd_ok   = r_en & ~r_empty_q & ~flush;
        w_ptr_d = w_ptr_q + (wr_ok ? W_ADDR_W'(1) : '0);
        r_ptr_d = r_ptr_q + (rd_ok ? R_ADDR_W'(1) : '0);
        level_d = level_q + (wr_ok ? W_INC_L : '0) - (rd_ok ? R_DEC_L : '0);
        if (flush) begin
            w_ptr_d = '0;
            r_ptr_d = '0;
            level_d = '0;
        end
        // Flags look ahead at the next level so they are correct the cycle it lands.
        w_full_d  = (level_d > FULL_THR);
        r_empty_d = (level_d < R_DEC_L);
        r_valid_d = rd_ok;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            w_ptr_q   <= '0;
            r_ptr_q   <= '0;
            level_q   <= '0;
            w_full_q  <= 1'b0;
            r_empty_q <= 1'b1;
            r_valid_q <= 1'b0;
        end else begin
            w_ptr_q   <= w_ptr_d;
            r_ptr_q   <= r_ptr_d;
            level_q   <= level_d;
            w_full_q  <= w_full_d;
            r_empty_q <= r_empty_d;
            r_valid_q <= r_valid_d;
        end
    end

`ifdef IOB_ASYM_FIFO_ERR_EN
    logic overflow_q, overflow_d, underflow_q, underflow_d;

    always_comb begin
        overflow_d  = flush ? 1'b0 : (overflow_q | (w_en & w_full_q));
        underflow_d = flush ? 1'b0 : (underflow_q | (r_en & r_empty_q));
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

    assign ram_w_en   = wr_ok;
    assign ram_w_data = w_data;
    assign ram_w_addr = w_ptr_q;
    assign ram_r_en   = rd_ok;
    assign ram_r_addr = r_ptr_q;
    assign r_data     = ram_r_data;
    assign r_valid    = r_valid_q;
    assign w_full     = w_full_q;
    assign r_empty    = r_empty_q;
    assign level      = level_q;

endmodule

// File: tb/tb_iob_asym_fifo_ctrl.sv
// Bench for iob_asym_fifo_ctrl: a 32->8 instance and an 8->32 instance, each with a behavioural asymmetric RAM.
module tb_iob_asym_fifo_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        a_flush, a_w_en, a_r_en, a_w_full, a_r_valid, a_r_empty;
    logic [31:0] a_w_data, a_ram_w_data;
    logic [7:0]  a_r_data, a_ram_r_data;
    logic [4:0]  a_level;
    logic        a_ram_w_en, a_ram_r_en;
    logic [1:0]  a_ram_w_addr;
    logic [3:0]  a_ram_r_addr;
    logic        a_ovf, a_udf;

    logic        b_flush, b_w_en, b_r_en, b_w_full, b_r_valid, b_r_empty;
    logic [7:0]  b_w_data, b_ram_w_data;
    logic [31:0] b_r_data, b_ram_r_data;
    logic [4:0]  b_level;
    logic        b_ram_w_en, b_ram_r_en;
    logic [3:0]  b_ram_w_addr;
    logic [1:0]  b_ram_r_addr;
    logic        b_ovf, b_udf;

    iob_asym_fifo_ctrl #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(4)) u_a (
        .ap_clk(clk), .ap_rst_n(rst_n), .flush(a_flush),
        .w_en(a_w_en), .w_data(a_w_data), .w_full(a_w_full),
        .r_en(a_r_en), .r_data(a_r_data), .r_valid(a_r_valid), .r_empty(a_r_empty),
        .level(a_level),
        .ram_w_en(a_ram_w_en), .ram_w_data(a_ram_w_data), .ram_w_addr(a_ram_w_addr),
        .ram_r_en(a_ram_r_en), .ram_r_addr(a_ram_r_addr),
`ifdef IOB_ASYM_FIFO_ERR_EN
        .overflow(a_ovf), .underflow(a_udf),
`endif
        .ram_r_data(a_ram_r_data)
    );

    iob_asym_fifo_ctrl #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4)) u_b (
        .ap_clk(clk), .ap_rst_n(rst_n), .flush(b_flush),
        .w_en(b_w_en), .w_data(b_w_data), .w_full(b_w_full),
        .r_en(b_r_en), .r_data(b_r_data), .r_valid(b_r_valid), .r_empty(b_r_empty),
        .level(b_level),
        .ram_w_en(b_ram_w_en), .ram_w_data(b_ram_w_data), .ram_w_addr(b_ram_w_addr),
        .ram_r_en(b_ram_r_en), .ram_r_addr(b_ram_r_addr),
`ifdef IOB_ASYM_FIFO_ERR_EN
        .overflow(b_ovf), .underflow(b_udf),
`endif
        .ram_r_data(b_ram_r_data)
    );

`ifndef IOB_ASYM_FIFO_ERR_EN
    assign a_ovf = 1'b0;
    assign a_udf = 1'b0;
    assign b_ovf = 1'b0;
    assign b_udf = 1'b0;
`endif

    // Little-endian asymmetric RAMs, one-cycle registered read
    logic [7:0] a_mem [16];
    logic [7:0] b_mem [16];

    always @(posedge clk) begin
        if (a_ram_w_en)
            for (int i = 0; i < 4; i++) a_mem[int'(a_ram_w_addr) * 4 + i] <= a_ram_w_data[8*i +: 8];
        if (a_ram_r_en) a_ram_r_data <= a_mem[a_ram_r_addr];
        if (b_ram_w_en) b_mem[b_ram_w_addr] <= b_ram_w_data;
        if (b_ram_r_en)
            for (int i = 0; i < 4; i++) b_ram_r_data[8*i +: 8] <= b_mem[int'(b_ram_r_addr) * 4 + i];
    end

    typedef struct {
        logic        w_en;
        logic [31:0] w_data;
        logic        r_en;
        logic        flush;
        logic        e_wen;
        logic        e_ren;
        logic [4:0]  e_level;
        logic        e_full;
        logic        e_empty;
        logic        e_ovf;
        logic        e_udf;
    } vec_t;

    int errs   = 0;
    int checks = 0;
    logic [7:0] sb_a [$];
    logic [7:0] sb_b [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] wd, input logic re, input logic fl,
                                input logic ewe, input logic ere, input logic [4:0] el,
                                input logic ef, input logic ee, input logic eo, input logic eu);
        vec_t v;
        v.w_en = we; v.w_data = wd; v.r_en = re; v.flush = fl;
        v.e_wen = ewe; v.e_ren = ere; v.e_level = el;
        v.e_full = ef; v.e_empty = ee; v.e_ovf = eo; v.e_udf = eu;
        return v;
    endfunction

    task automatic run_a(input vec_t v, input string tag);
        logic [7:0] exp_b;
        @(negedge clk);
        a_w_en = v.w_en; a_w_data = v.w_data; a_r_en = v.r_en; a_flush = v.flush;
        #1;
        chk({tag, " a.ram_w_en"}, 32'(a_ram_w_en), 32'(v.e_wen));
        chk({tag, " a.ram_r_en"}, 32'(a_ram_r_en), 32'(v.e_ren));
        if (v.flush) sb_a.delete();
        if (v.e_wen) for (int i = 0; i < 4; i++) sb_a.push_back(v.w_data[8*i +: 8]);
        @(posedge clk);
        #1;
        a_w_en = 1'b0; a_r_en = 1'b0; a_flush = 1'b0;
        chk({tag, " a.level"},   32'(a_level),   32'(v.e_level));
        chk({tag, " a.w_full"},  32'(a_w_full),  32'(v.e_full));
        chk({tag, " a.r_empty"}, 32'(a_r_empty), 32'(v.e_empty));
        chk({tag, " a.r_valid"}, 32'(a_r_valid), 32'(v.e_ren));
`ifdef IOB_ASYM_FIFO_ERR_EN
        chk({tag, " a.overflow"},  32'(a_ovf), 32'(v.e_ovf));
        chk({tag, " a.underflow"}, 32'(a_udf), 32'(v.e_udf));
`endif
        if (a_r_valid) begin
            if (sb_a.size() == 0) begin
                checks++; errs++;
                $display("FAIL %s a.r_data: got %h with no data expected", tag, a_r_data);
            end else begin
                exp_b = sb_a.pop_front();
                chk({tag, " a.r_data"}, 32'(a_r_data), 32'(exp_b));
            end
        end
    endtask

    task automatic run_b(input vec_t v, input string tag);
        logic [31:0] exp_w;
        @(negedge clk);
        b_w_en = v.w_en; b_w_data = v.w_data[7:0]; b_r_en = v.r_en; b_flush = v.flush;
        #1;
        chk({tag, " b.ram_w_en"}, 32'(b_ram_w_en), 32'(v.e_wen));
        chk({tag, " b.ram_r_en"}, 32'(b_ram_r_en), 32'(v.e_ren));
        if (v.flush) sb_b.delete();
        if (v.e_wen) sb_b.push_back(v.w_data[7:0]);
        @(posedge clk);
        #1;
        b_w_en = 1'b0; b_r_en = 1'b0; b_flush = 1'b0;
        chk({tag, " b.level"},   32'(b_level),   32'(v.e_level));
        chk({tag, " b.w_full"},  32'(b_w_full),  32'(v.e_full));
        chk({tag, " b.r_empty"}, 32'(b_r_empty), 32'(v.e_empty));
        chk({tag, " b.r_valid"}, 32'(b_r_valid), 32'(v.e_ren));
`ifdef IOB_ASYM_FIFO_ERR_EN
        chk({tag, " b.overflow"},  32'(b_ovf), 32'(v.e_ovf));
        chk({tag, " b.underflow"}, 32'(b_udf), 32'(v.e_udf));
`endif
        if (b_r_valid) begin
            if (sb_b.size() < 4) begin
                checks++; errs++;
                $display("FAIL %s b.r_data: got %h with too few bytes expected", tag, b_r_data);
            end else begin
                for (int i = 0; i < 4; i++) exp_w[8*i +: 8] = sb_b.pop_front();
                chk({tag, " b.r_data"}, b_r_data, exp_w);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tab_a [23];
        vec_t tab_b [11];
        logic [31:0] wd;

        //                  w_en wdata          r_en fl  wen ren lvl    full emp ovf udf
        tab_a[0]  = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b1);
        tab_a[1]  = mk(1'b1, 32'h44332211, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4,  1'b0, 1'b0, 1'b0, 1'b1);
        tab_a[2]  = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 5'd3,  1'b0, 1'b0, 1'b0, 1'b1);
        tab_a[3]  = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 5'd2,  1'b0, 1'b0, 1'b0, 1'b1);
        tab_a[4]  = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 5'd1,  1'b0, 1'b0, 1'b0, 1'b1);
        tab_a[5]  = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 5'd0,  1'b0, 1'b1, 1'b0, 1'b1);
        tab_a[6]  = mk(1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b1);
        tab_a[7]  = mk(1'b1, 32'h04030201, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4,  1'b0, 1'b0, 1'b0, 1'b1);
        tab_a[8]  = mk(1'b1, 32'h08070605, 1'b0, 1'b0, 1'b1, 1'b0, 5'd8,  1'b0, 1'b0, 1'b0, 1'b1);
        tab_a[9]  = mk(1'b1, 32'h0C0B0A09, 1'b1, 1'b0, 1'b1, 1'b1, 5'd11, 1'b0, 1'b0, 1'b0, 1'b1);
        tab_a[10] = mk(1'b1, 32'h100F0E0D, 1'b0, 1'b0, 1'b1, 1'b0, 5'd15, 1'b1, 1'b0, 1'b0, 1'b1);
        tab_a[11] = mk(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 5'd15, 1'b1, 1'b0, 1'b1, 1'b1);
        tab_a[12] = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 5'd14, 1'b1, 1'b0, 1'b1, 1'b1);
        tab_a[13] = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 5'd13, 1'b1, 1'b0, 1'b1, 1'b1);
        tab_a[14] = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 5'd12, 1'b0, 1'b0, 1'b1, 1'b1);
        tab_a[15] = mk(1'b1, 32'h14131211, 1'b0, 1'b0, 1'b1, 1'b0, 5'd16, 1'b1, 1'b0, 1'b1, 1'b1);
        tab_a[16] = mk(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 5'd16, 1'b1, 1'b0, 1'b1, 1'b1);
        tab_a[17] = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 5'd15, 1'b1, 1'b0, 1'b1, 1'b1);
        tab_a[18] = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 5'd14, 1'b1, 1'b0, 1'b1, 1'b1);
        tab_a[19] = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 5'd13, 1'b1, 1'b0, 1'b1, 1'b1);
        tab_a[20] = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 5'd12, 1'b0, 1'b0, 1'b1, 1'b1);
        tab_a[21] = mk(1'b1, 32'hCAFEF00D, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0);
        tab_a[22] = mk(1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b1);

        tab_b[0]  = mk(1'b1, 32'hAA, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        tab_b[1]  = mk(1'b1, 32'hBB, 1'b0, 1'b0, 1'b1, 1'b0, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        tab_b[2]  = mk(1'b1, 32'hCC, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        tab_b[3]  = mk(1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b1);
        tab_b[4]  = mk(1'b1, 32'hDD, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1);
        tab_b[5]  = mk(1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        tab_b[6]  = mk(1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b0, 1'b1, 1'b0, 1'b1);
        tab_b[7]  = mk(1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 1'b0, 5'd2, 1'b0, 1'b1, 1'b0, 1'b1);
        tab_b[8]  = mk(1'b1, 32'h33, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b1);
        tab_b[9]  = mk(1'b1, 32'h44, 1'b1, 1'b0, 1'b1, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1);
        tab_b[10] = mk(1'b1, 32'h55, 1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 1'b0, 1'b1, 1'b0, 1'b1);

        rst_n = 1'b0;
        a_flush = 1'b0; a_w_en = 1'b0; a_r_en = 1'b0; a_w_data = '0;
        b_flush = 1'b0; b_w_en = 1'b0; b_r_en = 1'b0; b_w_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset a.level",   32'(a_level),   32'd0);
        chk("reset a.w_full",  32'(a_w_full),  32'd0);
        chk("reset a.r_empty", 32'(a_r_empty), 32'd1);
        chk("reset a.r_valid", 32'(a_r_valid), 32'd0);
        chk("reset b.level",   32'(b_level),   32'd0);
        chk("reset b.r_empty", 32'(b_r_empty), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 23; i++) run_a(tab_a[i], $sformatf("tabA[%0d]", i));
        for (int i = 0; i < 11; i++) run_b(tab_b[i], $sformatf("tabB[%0d]", i));

        // Pointer wrap: 20 words through a 4-word buffer, byte order checked by the scoreboard
        for (int w = 0; w < 20; w++) begin
            wd = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
            run_a(mk(1'b1, wd, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1),
                  $sformatf("wrap w%0d", w));
            for (int k = 0; k < 4; k++)
                run_a(mk(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 5'(3 - k), 1'b0, (k == 3), 1'b0, 1'b1),
                      $sformatf("wrap r%0d.%0d", w, k));
        end

        // Async reset one cycle after an accepted read, with r_valid in flight
        run_a(mk(1'b1, 32'h55667788, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1), "prerst w");
        run_a(mk(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1), "prerst r");
        chk("prerst a.ram_r_addr", 32'(a_ram_r_addr), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst a.r_valid",    32'(a_r_valid),    32'd0);
        chk("arst a.level",      32'(a_level),      32'd0);
        chk("arst a.ram_w_addr", 32'(a_ram_w_addr), 32'd0);
        chk("arst a.ram_r_addr", 32'(a_ram_r_addr), 32'd0);
        chk("arst a.r_empty",    32'(a_r_empty),    32'd1);
        chk("arst a.w_full",     32'(a_w_full),     32'd0);
`ifdef IOB_ASYM_FIFO_ERR_EN
        chk("arst a.underflow",  32'(a_udf),        32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        sb_a.delete();
        run_a(mk(1'b1, 32'hA3A2A1A0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0), "postrst w");
        run_a(mk(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0), "postrst r");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
